pipelined_control_unit: RTL and testbench

- Five-stage successor to the single-cycle RV32I decoder.
- Decodes the D-stage instruction into a control bundle, then carries that bundle through ID/EX, EX/MEM and MEM/WB registers with bubble and flush support.
- Resolves branch and jump PCSrc in E.
- Sequences multi-cycle M-extension ops by stalling the front end.
- Sits between the instruction fetch/decode register and the datapath pipeline registers.

---
 rtl/pipelined_control_unit.sv | 395 +++++++++++++++++++++++++++++++++++++++
 tb/tb_pipelined_control_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_control_unit.sv
// Five-stage RV32I control unit: D-stage decode, ID/EX, EX/MEM and MEM/WB control registers, E-stage PCSrc.
// Optional RV32M_SEQ_EN adds M-extension decode and a multi-cycle sequencer that freezes the front end.
module pipelined_control_unit #(
  parameter int MD_CYCLES = 8,
  parameter int ALUCTL_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         instrD,
  input  logic                validD,
  input  logic                stallD,
  input  logic                flushE,
  input  logic                Zero,
  input  logic                signedLess,
  input  logic                unsignedLess,
  output logic [2:0]          ImmSrcD,
  output logic                RegWriteE,
  output logic                MemWriteE,
  output logic                ALUSrcAE,
  output logic                ALUSrcBE,
  output logic                LoadSignE,
  output logic [1:0]          ResultSrcE,
  output logic [1:0]          SizeSrcE,
  output logic [ALUCTL_W-1:0] ALUControlE,
  output logic [1:0]          PCSrcE,
  output logic                RegWriteM,
  output logic                MemWriteM,
  output logic                LoadSignM,
  output logic [1:0]          ResultSrcM,
  output logic [1:0]          SizeSrcM,
  output logic                RegWriteW,
  output logic [1:0]          ResultSrcW,
  output logic                illegalE,
  output logic                mdStall
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_LUI  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
`ifdef RV32M_SEQ_EN
  localparam logic [3:0] ALU_MUL  = 4'b1100;
  localparam logic [3:0] ALU_MULH = 4'b1101;
  localparam logic [3:0] ALU_DIV  = 4'b1110;
  localparam logic [3:0] ALU_REM  = 4'b1111;
`endif

  typedef struct packed {
    logic                reg_write;
    logic                mem_write;
    logic                alu_src_a;
    logic                alu_src_b;
    logic                load_sign;
    logic [1:0]          result_src;
    logic [1:0]          size_src;
    logic [ALUCTL_W-1:0] alu_ctl;
    logic                branch;
    logic                jump;
    logic                jalr;
    logic [2:0]          funct3;
`ifdef RV32M_SEQ_EN
    logic                md;
`endif
    logic                illegal;
  } ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       load_sign;
    logic [1:0] result_src;
    logic [1:0] size_src;
  } mem_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
  } wb_ctrl_t;

  localparam ctrl_t     BUBBLE     = '0;
  localparam mem_ctrl_t MEM_BUBBLE = '0;
  localparam wb_ctrl_t  WB_BUBBLE  = '0;

  function automatic logic [ALUCTL_W-1:0] alu_code(input logic [3:0] code);
    return ALUCTL_W'(code);
  endfunction

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic [6:0] funct7_s;
  ctrl_t      dec_s;
  logic [2:0] imm_src_s;
  ctrl_t      idex_d, idex_q;
  mem_ctrl_t  exmem_d, exmem_q;
  wb_ctrl_t   memwb_d, memwb_q;
  logic       branch_taken_s;
  logic [1:0] pc_src_s;
  logic       md_stall_s;
  logic       unused_s;

  assign opcode_s = instrD[6:0];
  assign funct3_s = instrD[14:12];
  assign funct7_s = instrD[31:25];

  // Register numbers belong to the datapath; only opcode/funct fields matter here.
`ifdef RV32M_SEQ_EN
  assign unused_s = ^{instrD[24:15], instrD[11:7]};
`else
  assign unused_s = ^{instrD[24:15], instrD[11:7], (MD_CYCLES < 2)};
`endif

  // D-stage decode of instrD into a control bundle and immediate select.
  always_comb begin
    dec_s     = BUBBLE;
    imm_src_s = 3'b000;
    case (opcode_s)
      7'b0110111: begin
        dec_s.reg_write = 1'b1;
        dec_s.alu_src_b = 1'b1;
        dec_s.alu_ctl   = alu_code(ALU_LUI);
        imm_src_s       = 3'b100;
      end
      7'b0010111: begin
        dec_s.reg_write = 1'b1;
        dec_s.alu_src_a = 1'b1;
        dec_s.alu_src_b = 1'b1;
        dec_s.alu_ctl   = alu_code(ALU_ADD);
        imm_src_s       = 3'b100;
      end
      7'b1101111: begin
        dec_s.reg_write  = 1'b1;
        dec_s.result_src = 2'b10;
        dec_s.jump       = 1'b1;
        imm_src_s        = 3'b011;
      end
      7'b1100111: begin
        dec_s.reg_write  = 1'b1;
        dec_s.result_src = 2'b10;
        dec_s.alu_src_b  = 1'b1;
        dec_s.alu_ctl    = alu_code(ALU_ADD);
        dec_s.jalr       = 1'b1;
        dec_s.illegal    = (funct3_s != 3'b000);
        imm_src_s        = 3'b000;
      end
      7'b1100011: begin
        dec_s.branch  = 1'b1;
        dec_s.funct3  = funct3_s;
        dec_s.alu_ctl = alu_code(ALU_SUB);
        dec_s.illegal = (funct3_s == 3'b010) || (funct3_s == 3'b011);
        imm_src_s     = 3'b010;
      end
      7'b0000011: begin
        dec_s.reg_write  = 1'b1;
        dec_s.result_src = 2'b01;
        dec_s.alu_src_b  = 1'b1;
        dec_s.alu_ctl    = alu_code(ALU_ADD);
        imm_src_s        = 3'b000;
        case (funct3_s)
          3'b000:  begin dec_s.size_src = 2'b10; dec_s.load_sign = 1'b1; end
          3'b001:  begin dec_s.size_src = 2'b01; dec_s.load_sign = 1'b1; end
          3'b010:  begin dec_s.size_src = 2'b00; dec_s.load_sign = 1'b1; end
          3'b100:  begin dec_s.size_src = 2'b10; dec_s.load_sign = 1'b0; end
          3'b101:  begin dec_s.size_src = 2'b01; dec_s.load_sign = 1'b0; end
          default: dec_s.illegal = 1'b1;
        endcase
      end
      7'b0100011: begin
        dec_s.mem_write = 1'b1;
        dec_s.alu_src_b = 1'b1;
        dec_s.alu_ctl   = alu_code(ALU_ADD);
        imm_src_s       = 3'b001;
        case (funct3_s)
          3'b000:  dec_s.size_src = 2'b10;
          3'b001:  dec_s.size_src = 2'b01;
          3'b010:  dec_s.size_src = 2'b00;
          default: dec_s.illegal = 1'b1;
        endcase
      end
      7'b0010011: begin
        dec_s.reg_write = 1'b1;
        dec_s.alu_src_b = 1'b1;
        imm_src_s       = 3'b000;
        case (funct3_s)
          3'b000: dec_s.alu_ctl = alu_code(ALU_ADD);
          3'b010: dec_s.alu_ctl = alu_code(ALU_SLT);
          3'b011: dec_s.alu_ctl = alu_code(ALU_SLTU);
          3'b100: dec_s.alu_ctl = alu_code(ALU_XOR);
          3'b110: dec_s.alu_ctl = alu_code(ALU_OR);
          3'b111: dec_s.alu_ctl = alu_code(ALU_AND);
          3'b001: begin
            dec_s.alu_ctl = alu_code(ALU_SLL);
            dec_s.illegal = (funct7_s != 7'b0000000);
          end
          3'b101: begin
            dec_s.alu_ctl = (funct7_s == 7'b0100000) ? alu_code(ALU_SRA) : alu_code(ALU_SRL);
            dec_s.illegal = (funct7_s != 7'b0000000) && (funct7_s != 7'b0100000);
          end
          default: dec_s.illegal = 1'b1;
        endcase
      end
      7'b0110011: begin
        dec_s.reg_write = 1'b1;
        case (funct7_s)
          7'b0000000: begin
            case (funct3_s)
              3'b000:  dec_s.alu_ctl = alu_code(ALU_ADD);
              3'b001:  dec_s.alu_ctl = alu_code(ALU_SLL);
              3'b010:  dec_s.alu_ctl = alu_code(ALU_SLT);
              3'b011:  dec_s.alu_ctl = alu_code(ALU_SLTU);
              3'b100:  dec_s.alu_ctl = alu_code(ALU_XOR);
              3'b101:  dec_s.alu_ctl = alu_code(ALU_SRL);
              3'b110:  dec_s.alu_ctl = alu_code(ALU_OR);
              3'b111:  dec_s.alu_ctl = alu_code(ALU_AND);
              default: dec_s.illegal = 1'b1;
            endcase
          end
          7'b0100000: begin
            case (funct3_s)
              3'b000:  dec_s.alu_ctl = alu_code(ALU_SUB);
              3'b101:  dec_s.alu_ctl = alu_code(ALU_SRA);
              default: dec_s.illegal = 1'b1;
            endcase
          end
`ifdef RV32M_SEQ_EN
          7'b0000001: begin
            dec_s.md = 1'b1;
            case (funct3_s)
              3'b000:  dec_s.alu_ctl = alu_code(ALU_MUL);
              3'b001:  dec_s.alu_ctl = alu_code(ALU_MULH);
              3'b100:  dec_s.alu_ctl = alu_code(ALU_DIV);
              3'b110:  dec_s.alu_ctl = alu_code(ALU_REM);
              default: dec_s.illegal = 1'b1;
            endcase
          end
`endif
          default: dec_s.illegal = 1'b1;
        endcase
      end
      default: dec_s.illegal = 1'b1;
    endcase
  end

  assign ImmSrcD = imm_src_s;

  // ID/EX next state: flush beats the MD hold, which beats stall/invalid bubbles.
  always_comb begin
    if (flushE) begin
      idex_d = BUBBLE;
    end else if (md_stall_s) begin
      idex_d = idex_q;
    end else if (stallD || !validD) begin
      idex_d = BUBBLE;
    end else if (dec_s.illegal) begin
      idex_d         = BUBBLE;
      idex_d.illegal = 1'b1;
    end else begin
      idex_d = dec_s;
    end
  end

  // EX/MEM and MEM/WB next state; M sees bubbles while an MD op is still computing.
  always_comb begin
    if (md_stall_s) begin
      exmem_d = MEM_BUBBLE;
    end else begin
      exmem_d.reg_write  = idex_q.reg_write;
      exmem_d.mem_write  = idex_q.mem_write;
      exmem_d.load_sign  = idex_q.load_sign;
      exmem_d.result_src = idex_q.result_src;
      exmem_d.size_src   = idex_q.size_src;
    end
    memwb_d.reg_write  = exmem_q.reg_write;
    memwb_d.result_src = exmem_q.result_src;
  end

  // Pipeline control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q  <= BUBBLE;
      exmem_q <= MEM_BUBBLE;
      memwb_q <= WB_BUBBLE;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  // Branch/jump resolution from the E-stage bundle and ALU flags.
  always_comb begin
    case (idex_q.funct3)
      3'b000:  branch_taken_s = Zero;
      3'b001:  branch_taken_s = !Zero;
      3'b100:  branch_taken_s = signedLess;
      3'b101:  branch_taken_s = !signedLess;
      3'b110:  branch_taken_s = unsignedLess;
      3'b111:  branch_taken_s = !unsignedLess;
      default: branch_taken_s = 1'b0;
    endcase
    if (idex_q.jalr) begin
      pc_src_s = 2'b10;
    end else if (idex_q.jump) begin
      pc_src_s = 2'b01;
    end else if (idex_q.branch && branch_taken_s) begin
      pc_src_s = 2'b01;
    end else begin
      pc_src_s = 2'b00;
    end
  end

`ifdef RV32M_SEQ_EN
  localparam int CNT_W = (MD_CYCLES > 2) ? $clog2(MD_CYCLES) : 1;

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

  md_state_t  md_state_d, md_state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic       md_stall_fsm_s;

  // MD sequencer: the first E cycle stalls from IDLE, then cnt counts the remaining stalled cycles.
  always_comb begin
    md_state_d     = md_state_q;
    cnt_d          = cnt_q;
    md_stall_fsm_s = 1'b0;
    case (md_state_q)
      MD_IDLE: begin
        if (idex_q.md && !flushE) begin
          md_stall_fsm_s = 1'b1;
          md_state_d     = MD_BUSY;
          cnt_d          = CNT_W'(MD_CYCLES - 2);
        end else begin
          md_state_d = MD_IDLE;
        end
      end
      MD_BUSY: begin
        if (flushE) begin
          md_state_d = MD_IDLE;
          cnt_d      = {CNT_W{1'b0}};
        end else if (cnt_q == {CNT_W{1'b0}}) begin
          md_state_d = MD_IDLE;
        end else begin
          md_stall_fsm_s = 1'b1;
          cnt_d          = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        md_state_d = MD_IDLE;
        cnt_d      = {CNT_W{1'b0}};
      end
    endcase
  end

  // MD sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      md_state_q <= MD_IDLE;
      cnt_q      <= {CNT_W{1'b0}};
    end else begin
      md_state_q <= md_state_d;
      cnt_q      <= cnt_d;
    end
  end

  assign md_stall_s = md_stall_fsm_s & ~rst;
`else
  assign md_stall_s = 1'b0;
`endif

  assign RegWriteE   = idex_q.reg_write;
  assign MemWriteE   = idex_q.mem_write;
  assign ALUSrcAE    = idex_q.alu_src_a;
  assign ALUSrcBE    = idex_q.alu_src_b;
  assign LoadSignE   = idex_q.load_sign;
  assign ResultSrcE  = idex_q.result_src;
  assign SizeSrcE    = idex_q.size_src;
  assign ALUControlE = idex_q.alu_ctl;
  assign illegalE    = idex_q.illegal;
  assign PCSrcE      = pc_src_s;
  assign RegWriteM   = exmem_q.reg_write;
  assign MemWriteM   = exmem_q.mem_write;
  assign LoadSignM   = exmem_q.load_sign;
  assign ResultSrcM  = exmem_q.result_src;
  assign SizeSrcM    = exmem_q.size_src;
  assign RegWriteW   = memwb_q.reg_write;
  assign ResultSrcW  = memwb_q.result_src;
  assign mdStall     = md_stall_s;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed-vector bench for pipelined_control_unit; expectations are hand-derived from the instruction encodings.
module tb_pipelined_control_unit;

  logic        clk = 1'b0;
  logic        rst, validD, stallD, flushE, Zero, signedLess, unsignedLess;
  logic [31:0] instrD;
  logic [2:0]  ImmSrcD;
  logic        RegWriteE, MemWriteE, ALUSrcAE, ALUSrcBE, LoadSignE;
  logic [1:0]  ResultSrcE, SizeSrcE, PCSrcE;
  logic [3:0]  ALUControlE;
  logic        RegWriteM, MemWriteM, LoadSignM;
  logic [1:0]  ResultSrcM, SizeSrcM;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic        illegalE, mdStall;

  int vec_cnt = 0;
  int err_cnt = 0;

  localparam logic [31:0] I_ADD  = 32'h003100B3;
  localparam logic [31:0] I_SUB  = 32'h403100B3;
  localparam logic [31:0] I_LW   = 32'h0000A083;
  localparam logic [31:0] I_SB   = 32'h00208023;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_JALR = 32'h000080E7;
  localparam logic [31:0] I_MUL  = 32'h023100B3;
  localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

  pipelined_control_unit #(.MD_CYCLES(8), .ALUCTL_W(4)) dut (
    .clk(clk), .rst(rst), .instrD(instrD), .validD(validD), .stallD(stallD), .flushE(flushE),
    .Zero(Zero), .signedLess(signedLess), .unsignedLess(unsignedLess), .ImmSrcD(ImmSrcD),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE),
    .LoadSignE(LoadSignE), .ResultSrcE(ResultSrcE), .SizeSrcE(SizeSrcE), .ALUControlE(ALUControlE),
    .PCSrcE(PCSrcE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .LoadSignM(LoadSignM),
    .ResultSrcM(ResultSrcM), .SizeSrcM(SizeSrcM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .illegalE(illegalE), .mdStall(mdStall)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  // Branch table: instruction, Zero, signedLess, unsignedLess, expected PCSrcE.
  logic [31:0] br_instr [7] = '{32'h00208463, 32'h00208463, 32'h00209463, 32'h0020C463,
                                32'h0020D463, 32'h0020E463, 32'h0020F463};
  logic [2:0]  br_flags [7] = '{3'b100, 3'b000, 3'b000, 3'b010, 3'b010, 3'b001, 3'b001};
  logic [1:0]  br_exp   [7] = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall_cnt;
    int pulse_cnt;
    rst = 1'b1; instrD = I_ADD; validD = 1'b1; stallD = 1'b0; flushE = 1'b0;
    Zero = 1'b0; signedLess = 1'b0; unsignedLess = 1'b0;

    tick();
    check_vec("rst_regwrite_e", {31'd0, RegWriteE}, 32'd0);
    check_vec("rst_memwrite_e", {31'd0, MemWriteE}, 32'd0);
    check_vec("rst_regwrite_m", {31'd0, RegWriteM}, 32'd0);
    check_vec("rst_memwrite_m", {31'd0, MemWriteM}, 32'd0);
    check_vec("rst_regwrite_w", {31'd0, RegWriteW}, 32'd0);
    check_vec("rst_mdstall", {31'd0, mdStall}, 32'd0);
    check_vec("rst_illegal", {31'd0, illegalE}, 32'd0);

    rst = 1'b0;
    tick();
    check_vec("add_aluctl_e", {28'd0, ALUControlE}, 32'h0);
    check_vec("add_regwrite_e", {31'd0, RegWriteE}, 32'd1);
    check_vec("add_srca_e", {31'd0, ALUSrcAE}, 32'd0);
    instrD = I_SUB;
    tick();
    check_vec("sub_aluctl_e", {28'd0, ALUControlE}, 32'h1);
    check_vec("add_regwrite_m", {31'd0, RegWriteM}, 32'd1);
    check_vec("add_regwrite_w_early", {31'd0, RegWriteW}, 32'd0);
    validD = 1'b0;
    tick();
    check_vec("bubble_regwrite_e", {31'd0, RegWriteE}, 32'd0);
    check_vec("sub_regwrite_m", {31'd0, RegWriteM}, 32'd1);
    check_vec("add_regwrite_w", {31'd0, RegWriteW}, 32'd1);
    tick();
    check_vec("bubble_regwrite_m", {31'd0, RegWriteM}, 32'd0);
    check_vec("sub_regwrite_w", {31'd0, RegWriteW}, 32'd1);

    for (int i = 0; i < 7; i++) begin
      instrD = br_instr[i]; validD = 1'b1;
      settle();
      if (i == 0) check_vec("br_immsrc_d", {29'd0, ImmSrcD}, 32'h2);
      tick();
      validD = 1'b0;
      {Zero, signedLess, unsignedLess} = br_flags[i];
      settle();
      check_vec($sformatf("br%0d_pcsrc", i), {30'd0, PCSrcE}, {30'd0, br_exp[i]});
      check_vec($sformatf("br%0d_regwrite", i), {31'd0, RegWriteE}, 32'd0);
    end
    Zero = 1'b0; signedLess = 1'b0; unsignedLess = 1'b0;

    instrD = I_ADD; validD = 1'b1;
    tick();
    check_vec("pre_flush_regwrite_e", {31'd0, RegWriteE}, 32'd1);
    flushE = 1'b1;
    tick();
    check_vec("flush_regwrite_e", {31'd0, RegWriteE}, 32'd0);
    flushE = 1'b0;
    tick();
    check_vec("reload_regwrite_e", {31'd0, RegWriteE}, 32'd1);
    flushE = 1'b1; stallD = 1'b1;
    tick();
    check_vec("stall_flush_regwrite_e", {31'd0, RegWriteE}, 32'd0);
    flushE = 1'b0;
    tick();
    check_vec("stall_regwrite_e", {31'd0, RegWriteE}, 32'd0);
    stallD = 1'b0;

    instrD = I_LW;
    settle();
    check_vec("lw_immsrc_d", {29'd0, ImmSrcD}, 32'h0);
    tick();
    check_vec("lw_resultsrc_e", {30'd0, ResultSrcE}, 32'h1);
    check_vec("lw_sizesrc_e", {30'd0, SizeSrcE}, 32'h0);
    check_vec("lw_loadsign_e", {31'd0, LoadSignE}, 32'd1);
    check_vec("lw_srcb_e", {31'd0, ALUSrcBE}, 32'd1);
    instrD = I_SB;
    settle();
    check_vec("sb_immsrc_d", {29'd0, ImmSrcD}, 32'h1);
    tick();
    check_vec("sb_memwrite_e", {31'd0, MemWriteE}, 32'd1);
    check_vec("sb_sizesrc_e", {30'd0, SizeSrcE}, 32'h2);
    check_vec("sb_regwrite_e", {31'd0, RegWriteE}, 32'd0);
    check_vec("lw_loadsign_m", {31'd0, LoadSignM}, 32'd1);
    check_vec("lw_resultsrc_m", {30'd0, ResultSrcM}, 32'h1);
    validD = 1'b0;
    tick();
    check_vec("sb_memwrite_m", {31'd0, MemWriteM}, 32'd1);
    check_vec("sb_sizesrc_m", {30'd0, SizeSrcM}, 32'h2);
    check_vec("lw_resultsrc_w", {30'd0, ResultSrcW}, 32'h1);

    instrD = I_JAL; validD = 1'b1;
    settle();
    check_vec("jal_immsrc_d", {29'd0, ImmSrcD}, 32'h3);
    tick();
    check_vec("jal_pcsrc", {30'd0, PCSrcE}, 32'h1);
    check_vec("jal_resultsrc_e", {30'd0, ResultSrcE}, 32'h2);
    instrD = I_JALR;
    tick();
    check_vec("jalr_pcsrc", {30'd0, PCSrcE}, 32'h2);
    instrD = I_BAD;
    tick();
    check_vec("bad_illegal", {31'd0, illegalE}, 32'd1);
    check_vec("bad_regwrite_e", {31'd0, RegWriteE}, 32'd0);
    check_vec("bad_memwrite_e", {31'd0, MemWriteE}, 32'd0);
    check_vec("bad_pcsrc", {30'd0, PCSrcE}, 32'h0);
    validD = 1'b0;
    tick();
    check_vec("bad_cleared", {31'd0, illegalE}, 32'd0);
    tick();

    instrD = I_MUL; validD = 1'b1;
    tick();
    validD = 1'b0;
    settle();
`ifdef RV32M_SEQ_EN
    stall_cnt = 0;
    pulse_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      check_vec($sformatf("mul_aluctl_c%0d", k), {28'd0, ALUControlE}, 32'hC);
      if (mdStall) stall_cnt++;
      if (RegWriteM) pulse_cnt++;
      if (k < 7) tick();
    end
    check_vec("mul_last_cycle_nostall", {31'd0, mdStall}, 32'd0);
    tick();
    if (RegWriteM) pulse_cnt++;
    check_vec("mul_left_e", {28'd0, ALUControlE}, 32'h0);
    tick();
    if (RegWriteM) pulse_cnt++;
    check_vec("mul_stall_cycles", stall_cnt, 32'd7);
    check_vec("mul_m_pulses", pulse_cnt, 32'd1);

    instrD = I_MUL; validD = 1'b1;
    tick();
    validD = 1'b0;
    settle();
    check_vec("mulf_stall_c0", {31'd0, mdStall}, 32'd1);
    tick();
    check_vec("mulf_stall_c1", {31'd0, mdStall}, 32'd1);
    tick();
    flushE = 1'b1;
    settle();
    check_vec("mulf_flush_drop", {31'd0, mdStall}, 32'd0);
    tick();
    flushE = 1'b0;
    settle();
    check_vec("mulf_after_stall", {31'd0, mdStall}, 32'd0);
    check_vec("mulf_after_regwrite_e", {31'd0, RegWriteE}, 32'd0);
    check_vec("mulf_after_aluctl", {28'd0, ALUControlE}, 32'h0);
`else
    stall_cnt = 0;
    pulse_cnt = 0;
    check_vec("mul_illegal", {31'd0, illegalE}, 32'd1);
    check_vec("mul_nostall", {31'd0, mdStall}, 32'd0);
    check_vec("mul_regwrite_e", {31'd0, RegWriteE}, 32'd0);
    tick();
    if (mdStall) stall_cnt++;
    if (RegWriteM) pulse_cnt++;
    check_vec("mul_no_m_write", pulse_cnt, 32'd0);
    check_vec("mul_no_stall_after", stall_cnt, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
